// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, datapath mux selects, opcodes.
// Pure types and constants; no timing and no flow control of its own.
package cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ResultSrc selects
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Instruction classes carried in Op
   localparam logic [1:0] OP_DP     = 2'b00;
   localparam logic [1:0] OP_MEM    = 2'b01;
   localparam logic [1:0] OP_BRANCH = 2'b10;
   localparam logic [1:0] OP_BAD    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_w;
      logic       reg_w;
      logic       branch;
      logic       adr_src;
      logic       alu_src_a;
      logic       alu_op;
      logic [1:0] result_src;
      logic [1:0] alu_src_b;
   } ctrl_t;

   // States that issue a memory access and may stall on mem_ready
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Per-access wait counter (8-bit, saturating) with timeout compare; timeout is combinational off the count.
// No backpressure: the counter clears whenever the FSM is not holding in a memory state.
module cu_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic mem_ready,
   output logic timeout
);

   logic [7:0] count;

   // Clearing on every non-hold cycle gives a zero count on entry to any memory state.
   always_ff @(posedge clk) begin
      if (rst || !hold) begin
         count <= 8'd0;
      end else if (!mem_ready && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

   assign timeout = (TIMEOUT != 0) && !mem_ready && (count == 8'(TIMEOUT));

endmodule

// File: rtl/cu_multicycle_fsm.sv
// Multicycle CPU control unit: Moore FSM; branch 3, data-processing 4, store 4, load 5 cycles without waits.
// Memory states stall on mem_ready when MEM_HANDSHAKE=1 and abandon the access after MEM_TIMEOUT wait cycles.
module cu_multicycle_fsm
   import cu_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemW,
   output logic       RegW,
   output logic       Branch,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic       ALUOp,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state_o
);

   state_t state;
   state_t state_nxt;
   logic   ill_nxt;
   logic   err_nxt;
   logic   done;
   logic   timeout;
   logic   hold;
   ctrl_t  ctrl;
   logic   unused_funct;

   assign unused_funct = ^Funct[4:1];

   assign done = (MEM_HANDSHAKE == 0) || mem_ready;
   assign hold = is_wait_state(state) && !done && !timeout;

   // Without a handshake an access can never stall, so the timeout is disabled outright.
   cu_wait_timer #(
      .TIMEOUT((MEM_HANDSHAKE != 0) ? MEM_TIMEOUT : 0)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         illegal_op <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         illegal_op <= ill_nxt;
         mem_err    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = S_FETCH;
      ill_nxt   = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         S_FETCH: begin
            if (done) begin
               state_nxt = S_DECODE;
            end else if (timeout) begin
               err_nxt = 1'b1;
            end
         end
         S_DECODE: begin
            case (Op)
               OP_DP:     state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:    state_nxt = S_MEMADR;
               OP_BRANCH: state_nxt = S_BRANCH;
               OP_BAD:    ill_nxt   = 1'b1;
            endcase
         end
         S_MEMADR:   state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         // Completion is tested before timeout so a late mem_ready still wins.
         S_MEMREAD: begin
            if (done) begin
               state_nxt = S_MEMWB;
            end else if (timeout) begin
               err_nxt = 1'b1;
            end else begin
               state_nxt = S_MEMREAD;
            end
         end
         S_MEMWRITE: begin
            if (!done && timeout) begin
               err_nxt = 1'b1;
            end else if (!done) begin
               state_nxt = S_MEMWRITE;
            end
         end
         S_EXECUTER: state_nxt = S_ALUWB;
         S_EXECUTEI: state_nxt = S_ALUWB;
         default:    state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      if (rst) begin
         ctrl.alu_src_a  = 1'b1;
         ctrl.alu_src_b  = SRCB_FOUR;
         ctrl.result_src = RES_ALU;
      end else begin
         case (state)
            S_FETCH: begin
               ctrl.ir_write   = done;
               ctrl.pc_write   = done;
               ctrl.alu_src_a  = 1'b1;
               ctrl.alu_src_b  = SRCB_FOUR;
               ctrl.result_src = RES_ALU;
            end
            S_DECODE: begin
               ctrl.alu_src_a  = 1'b1;
               ctrl.alu_src_b  = SRCB_FOUR;
               ctrl.result_src = RES_ALU;
            end
            S_MEMADR: begin
               ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
               ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
               ctrl.result_src = RES_DATA;
               ctrl.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
               ctrl.adr_src = 1'b1;
               ctrl.mem_w   = 1'b1;
            end
            S_EXECUTER: begin
               ctrl.alu_src_b = SRCB_REG;
               ctrl.alu_op    = 1'b1;
            end
            S_EXECUTEI: begin
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
               ctrl.result_src = RES_ALUOUT;
               ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.result_src = RES_ALU;
               ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign PCWrite   = ctrl.pc_write;
   assign IRWrite   = ctrl.ir_write;
   assign MemW      = ctrl.mem_w;
   assign RegW      = ctrl.reg_w;
   assign Branch    = ctrl.branch;
   assign AdrSrc    = ctrl.adr_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUOp     = ctrl.alu_op;
   assign ResultSrc = ctrl.result_src;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign state_o   = state;

endmodule

// File: tb/tb_cu_multicycle_fsm.sv
// Bench for cu_multicycle_fsm: per-instruction expected traces built from cycle counts and wait lengths.
// Two instances cover handshake (timeout 4) and no-handshake configurations.
module tb_cu_multicycle_fsm;

   typedef struct packed {
      logic        rst;
      logic        mr;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  st;
      logic [13:0] ctl;
   } rec_t;

   // control word: PCWrite IRWrite MemW RegW Branch AdrSrc ALUSrcA ALUOp ResultSrc[1:0] ALUSrcB[1:0]
   localparam logic [11:0] F_GO   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10};
   localparam logic [11:0] F_WAIT = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10};
   localparam logic [11:0] MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
   localparam logic [11:0] MRD    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
   localparam logic [11:0] MWB    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
   localparam logic [11:0] MWR    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
   localparam logic [11:0] EXR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
   localparam logic [11:0] EXI    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
   localparam logic [11:0] AWB    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
   localparam logic [11:0] BRC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_ready = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic       sel = 1'b0;

   wire [13:0] ctl_h;
   wire [13:0] ctl_n;
   wire [3:0]  st_h;
   wire [3:0]  st_n;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   hs = 1'b1;
   int   tmo = 4;
   bit   pend_ill = 1'b0;
   bit   pend_err = 1'b0;
   logic [1:0] cur_op = 2'b00;
   logic [5:0] cur_funct = 6'd0;
   rec_t q[$];

   always #5 clk = ~clk;

   cu_multicycle_fsm #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(4)) dut_h (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
      .PCWrite(ctl_h[13]), .IRWrite(ctl_h[12]), .MemW(ctl_h[11]), .RegW(ctl_h[10]),
      .Branch(ctl_h[9]), .AdrSrc(ctl_h[8]), .ALUSrcA(ctl_h[7]), .ALUOp(ctl_h[6]),
      .ResultSrc(ctl_h[5:4]), .ALUSrcB(ctl_h[3:2]), .illegal_op(ctl_h[1]), .mem_err(ctl_h[0]),
      .state_o(st_h)
   );

   cu_multicycle_fsm #(.MEM_HANDSHAKE(0), .MEM_TIMEOUT(15)) dut_n (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
      .PCWrite(ctl_n[13]), .IRWrite(ctl_n[12]), .MemW(ctl_n[11]), .RegW(ctl_n[10]),
      .Branch(ctl_n[9]), .AdrSrc(ctl_n[8]), .ALUSrcA(ctl_n[7]), .ALUOp(ctl_n[6]),
      .ResultSrc(ctl_n[5:4]), .ALUSrcB(ctl_n[3:2]), .illegal_op(ctl_n[1]), .mem_err(ctl_n[0]),
      .state_o(st_n)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic rmr();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [3:0] st, input logic mr, input logic [11:0] c);
      rec_t r;
      r.rst = 1'b0; r.mr = mr; r.op = cur_op; r.funct = cur_funct; r.st = st;
      r.ctl = {c, pend_ill, pend_err};
      pend_ill = 1'b0; pend_err = 1'b0;
      q.push_back(r);
   endtask

   // Reset cycle: state register still holds its old value, strobes are off, flags still show last cycle.
   task automatic push_rst(input logic [3:0] st, input logic [1:0] flags);
      rec_t r;
      r.rst = 1'b1; r.mr = rmr(); r.op = cur_op; r.funct = cur_funct; r.st = st;
      r.ctl = {F_WAIT, flags};
      pend_ill = 1'b0; pend_err = 1'b0;
      q.push_back(r);
   endtask

   // w = number of cycles mem_ready stays low before it is raised
   task automatic mem_phase(input logic [3:0] st, input logic [11:0] c_wait, input logic [11:0] c_go,
                            input int w, output bit aborted);
      aborted = 1'b0;
      if (!hs) begin
         push(st, rmr(), c_go);
      end else if (tmo != 0 && w > tmo) begin
         for (int k = 0; k <= tmo; k++) push(st, 1'b0, c_wait);
         pend_err = 1'b1;
         aborted = 1'b1;
      end else begin
         for (int k = 0; k < w; k++) push(st, 1'b0, c_wait);
         push(st, 1'b1, c_go);
      end
   endtask

   task automatic instr(input logic [1:0] op, input logic [5:0] funct, input int wf, input int wm);
      bit ab;
      cur_op = op; cur_funct = funct;
      mem_phase(4'd0, F_WAIT, F_GO, wf, ab);
      if (ab) return;
      push(4'd1, rmr(), F_WAIT);
      case (op)
         2'd0: begin
            push(funct[5] ? 4'd7 : 4'd6, rmr(), funct[5] ? EXI : EXR);
            push(4'd8, rmr(), AWB);
         end
         2'd1: begin
            push(4'd2, rmr(), MADR);
            if (funct[0]) begin
               mem_phase(4'd3, MRD, MRD, wm, ab);
               if (!ab) push(4'd4, rmr(), MWB);
            end else begin
               mem_phase(4'd5, MWR, MWR, wm, ab);
            end
         end
         2'd2: push(4'd9, rmr(), BRC);
         default: pend_ill = 1'b1;
      endcase
   endtask

   task automatic instr_cut(input logic [1:0] op, input logic [5:0] funct, input int wf, input int wm,
                            input bit in_write);
      rec_t r;
      int   i;
      instr(op, funct, wf, wm);
      i = $urandom_range(0, q.size() - 1);
      if (in_write) begin
         for (int k = 0; k < q.size(); k++) if (q[k].st == 4'd5) i = k;
      end
      r = q[i];
      while (q.size() > i) void'(q.pop_back());
      push_rst(r.st, r.ctl[1:0]);
   endtask

   task automatic run_q();
      rec_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(negedge clk);
         rst = r.rst; mem_ready = r.mr; Op = r.op; Funct = r.funct;
         #1;
         check_val("state", {28'd0, sel ? st_n : st_h}, {28'd0, r.st});
         check_val("ctl", {18'd0, sel ? ctl_n : ctl_h}, {18'd0, r.ctl});
         cyc++;
      end
   endtask

   task automatic rand_instr(input bit allow_cut);
      logic [1:0] op;
      logic [5:0] funct;
      int wf, wm;
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom_range(0, 63));
      wf = $urandom_range(0, 6);
      wm = $urandom_range(0, 6);
      if (allow_cut && $urandom_range(0, 7) == 0) instr_cut(op, funct, wf, wm, 1'b0);
      else instr(op, funct, wf, wm);
   endtask

   initial begin
      // handshake instance, timeout 4
      sel = 1'b0; hs = 1'b1; tmo = 4;
      @(posedge clk);
      push_rst(4'd0, 2'b00);
      instr(2'd0, 6'h00, 0, 0);       // R-type, no waits: 0,1,6,8
      instr(2'd1, 6'h01, 0, 3);       // load with 3 wait cycles
      instr(2'd1, 6'h00, 0, 100);     // store, timeout after 5 MemW cycles
      instr(2'd3, 6'h00, 0, 0);       // illegal opcode
      instr(2'd1, 6'h01, 0, 4);       // ready exactly at the timeout count
      instr(2'd0, 6'h20, 9, 0);       // fetch timeout
      instr(2'd0, 6'h20, 2, 0);
      instr(2'd2, 6'h00, 1, 0);
      instr_cut(2'd1, 6'h00, 0, 100, 1'b1);  // reset mid-write wait
      instr(2'd1, 6'h00, 0, 100);     // counter restarted from zero
      instr(2'd1, 6'h00, 0, 0);
      run_q();
      for (int n = 0; n < 80; n++) begin
         rand_instr(1'b1);
         run_q();
      end

      // no-handshake instance
      sel = 1'b1; hs = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      push_rst(4'd0, 2'b00);
      instr(2'd2, 6'h00, 0, 0);
      instr(2'd1, 6'h01, 0, 0);
      instr(2'd1, 6'h00, 0, 0);
      instr(2'd3, 6'h00, 0, 0);
      run_q();
      for (int n = 0; n < 50; n++) begin
         rand_instr(1'b1);
         run_q();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
